// File: rtl/sysx_target.sv
// sysX bus target: synchronizes the master's bus signals into the local clock domain and
// turns command/data frames into single-cycle local register write/read strobes.
module sysx_target #(
  parameter logic [1:0] ADDRESS = 2'd1
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iBusClock,
  input  logic [1:0]  iBusSelect,
  input  logic [7:0]  iBusMOSI,
  output logic [7:0]  oBusMISO,
  output logic        oBusMISOEnable,
  output logic        oBusInterrupt,
  output logic [3:0]  oLocalAddress,
  output logic [31:0] oLocalData,
  output logic        oLocalWrite,
  output logic        oLocalRead,
  input  logic [31:0] iLocalData,
  input  logic        iLocalInterrupt
);

  typedef enum logic [2:0] {IDLE, COMMAND, WDATA, WCOMMIT, RFETCH, RDATA, DONE} stateType;

  logic       busClkMeta, busClkSync, busClkPrev;
  logic [1:0] selectMeta, selectSync;
  logic [7:0] mosiMeta, mosiSync;

  stateType    stateReg, stateNext;
  logic [2:0]  byteCountReg, byteCountNext;
  logic        fetchPhaseReg, fetchPhaseNext;
  logic [31:0] shiftReg, shiftNext;
  logic [7:0]  misoReg, misoNext;
  logic [3:0]  addressReg, addressNext;
  logic [31:0] dataReg, dataNext;
  logic        writeReg, writeNext;
  logic        readReg, readNext;
  logic        interruptReg;

  logic busRise, busFall, selected;

  // MOSI shares the clock's synchronizer depth, so it is stable when the edge is detected.
  assign busRise  = busClkSync & ~busClkPrev;
  assign busFall  = ~busClkSync & busClkPrev;
  assign selected = (selectSync == ADDRESS);

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      busClkMeta    <= 1'b0;
      busClkSync    <= 1'b0;
      busClkPrev    <= 1'b0;
      selectMeta    <= 2'd0;
      selectSync    <= 2'd0;
      mosiMeta      <= 8'h00;
      mosiSync      <= 8'h00;
      stateReg      <= IDLE;
      byteCountReg  <= 3'd0;
      fetchPhaseReg <= 1'b0;
      shiftReg      <= 32'h0;
      misoReg       <= 8'h00;
      addressReg    <= 4'h0;
      dataReg       <= 32'h0;
      writeReg      <= 1'b0;
      readReg       <= 1'b0;
      interruptReg  <= 1'b0;
    end else begin
      busClkMeta    <= iBusClock;
      busClkSync    <= busClkMeta;
      busClkPrev    <= busClkSync;
      selectMeta    <= iBusSelect;
      selectSync    <= selectMeta;
      mosiMeta      <= iBusMOSI;
      mosiSync      <= mosiMeta;
      stateReg      <= stateNext;
      byteCountReg  <= byteCountNext;
      fetchPhaseReg <= fetchPhaseNext;
      shiftReg      <= shiftNext;
      misoReg       <= misoNext;
      addressReg    <= addressNext;
      dataReg       <= dataNext;
      writeReg      <= writeNext;
      readReg       <= readNext;
      interruptReg  <= iLocalInterrupt;
    end
  end

  always_comb begin
    stateNext      = stateReg;
    byteCountNext  = byteCountReg;
    fetchPhaseNext = fetchPhaseReg;
    shiftNext      = shiftReg;
    misoNext       = misoReg;
    addressNext    = addressReg;
    dataNext       = dataReg;
    writeNext      = 1'b0;
    readNext       = 1'b0;
    if (!selected) begin
      stateNext = IDLE;
    end else begin
      case (stateReg)
        IDLE: stateNext = COMMAND;
        COMMAND: begin
          if (busRise) begin
            addressNext    = mosiSync[3:0];
            byteCountNext  = 3'd0;
            fetchPhaseNext = 1'b0;
            if (mosiSync[7]) begin
              stateNext = WDATA;
            end else begin
              stateNext = RFETCH;
              readNext  = 1'b1;
            end
          end
        end
        WDATA: begin
          if (busRise) begin
            dataNext      = {dataReg[23:0], mosiSync};
            byteCountNext = byteCountReg + 3'd1;
            if (byteCountReg == 3'd3) stateNext = WCOMMIT;
          end
        end
        WCOMMIT: begin
          writeNext = 1'b1;
          stateNext = DONE;
        end
        // Phase 0 is the read-strobe cycle; the local side answers during phase 1.
        RFETCH: begin
          if (!fetchPhaseReg) begin
            fetchPhaseNext = 1'b1;
          end else begin
            shiftNext     = iLocalData;
            byteCountNext = 3'd0;
            stateNext     = RDATA;
          end
        end
        RDATA: begin
          if (busFall && byteCountReg != 3'd4) begin
            misoNext      = shiftReg[31:24];
            shiftNext     = {shiftReg[23:0], 8'h00};
            byteCountNext = byteCountReg + 3'd1;
          end else if (busRise && byteCountReg == 3'd4) begin
            stateNext = DONE;
          end
        end
        DONE:    stateNext = DONE;
        default: stateNext = IDLE;
      endcase
    end
    if (stateNext != RDATA && stateNext != DONE) misoNext = 8'h00;
  end

  assign oBusMISO       = misoReg;
  assign oBusMISOEnable = selected;
  assign oBusInterrupt  = interruptReg;
  assign oLocalAddress  = addressReg;
  assign oLocalData     = dataReg;
  assign oLocalWrite    = writeReg;
  assign oLocalRead     = readReg;

endmodule

// File: tb/tb_sysx_target.sv
// Bench for sysx_target: a sysX master drives frames, a local register-file peripheral
// answers strobes, and a scoreboard checks strobes against a register-map model.
module tb_sysx_target;
  localparam logic [1:0] ADDR = 2'd1;
  localparam int H = 97;

  logic        iClock, iReset, iBusClock;
  logic [1:0]  iBusSelect;
  logic [7:0]  iBusMOSI;
  logic [7:0]  oBusMISO;
  logic        oBusMISOEnable, oBusInterrupt;
  logic [3:0]  oLocalAddress;
  logic [31:0] oLocalData;
  logic        oLocalWrite, oLocalRead;
  logic [31:0] iLocalData;
  logic        iLocalInterrupt;

  sysx_target #(.ADDRESS(ADDR)) dut (
    .iClock(iClock), .iReset(iReset), .iBusClock(iBusClock), .iBusSelect(iBusSelect),
    .iBusMOSI(iBusMOSI), .oBusMISO(oBusMISO), .oBusMISOEnable(oBusMISOEnable),
    .oBusInterrupt(oBusInterrupt), .oLocalAddress(oLocalAddress), .oLocalData(oLocalData),
    .oLocalWrite(oLocalWrite), .oLocalRead(oLocalRead), .iLocalData(iLocalData),
    .iLocalInterrupt(iLocalInterrupt)
  );

  typedef struct {
    bit         isWrite;
    logic [3:0] addr;
    logic [31:0] data;
  } expT;

  expT         expQ[$];
  logic [31:0] mem[16];
  logic [31:0] modelRegs[16];
  int total = 0;
  int bad = 0;
  int txn = 0;
  int enHigh = 0;
  bit watchEnable = 0;
  bit done = 0;

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Local peripheral: a register file answering one cycle after the read strobe.
  always @(posedge iClock) begin
    if (oLocalWrite) mem[oLocalAddress] <= oLocalData;
    if (oLocalRead) iLocalData <= mem[oLocalAddress];
  end

  // Scoreboard monitor: every strobe must match the oldest expected transaction.
  initial begin
    expT e;
    while (!done) begin
      @(negedge iClock);
      if (oLocalWrite || oLocalRead) begin
        check("single_strobe", {31'd0, oLocalWrite & oLocalRead}, 32'd0);
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got write=%0b read=%0b addr %h want none",
                   oLocalWrite, oLocalRead, oLocalAddress);
        end else begin
          e = expQ.pop_front();
          check("strobe_kind", {31'd0, oLocalWrite}, {31'd0, e.isWrite});
          check("strobe_addr", {28'd0, oLocalAddress}, {28'd0, e.addr});
          if (e.isWrite) check("write_data", oLocalData, e.data);
        end
      end
      if (watchEnable && oBusMISOEnable) enHigh++;
    end
  end

  initial begin
    iLocalInterrupt = 1'b0;
    while (!done) begin
      @(negedge iClock);
      if ($urandom_range(0, 15) == 0) iLocalInterrupt = ~iLocalInterrupt;
    end
  end

  initial begin
    logic s, rstAtEdge;
    while (!done) begin
      @(posedge iClock);
      s = iLocalInterrupt;
      rstAtEdge = iReset;
      #1;
      if (!rstAtEdge && !iReset) check("interrupt", {31'd0, oBusInterrupt}, {31'd0, s});
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  task automatic busFrame(input logic [1:0] sel, input logic [7:0] cmd, input logic [31:0] wdata,
                          input int nEdges, output logic [31:0] rdata);
    logic [7:0] b;
    rdata = 32'h0;
    iBusSelect = sel;
    #150;
    check("select_enable", {31'd0, oBusMISOEnable}, {31'd0, sel == ADDR});
    for (int k = 0; k < nEdges; k++) begin
      if (k == 0) b = cmd;
      else if (cmd[7]) b = 8'(wdata >> (8 * (4 - k)));
      else b = 8'($urandom);
      iBusMOSI = b;
      #H;
      if (!cmd[7] && k >= 1) rdata = {rdata[23:0], oBusMISO};
      iBusClock = 1'b1;
      #H;
      iBusClock = 1'b0;
    end
  endtask

  task automatic deselect();
    #50;
    iBusSelect = 2'd0;
    #60;
    check("deselect_enable", {31'd0, oBusMISOEnable}, 32'd0);
    check("idle_miso", {24'd0, oBusMISO}, 32'd0);
    #40;
  endtask

  task automatic doWrite(input logic [1:0] sel, input logic [7:0] cmd, input logic [31:0] data);
    logic [31:0] r;
    expT e;
    if (sel == ADDR) begin
      e.isWrite = 1'b1;
      e.addr = cmd[3:0];
      e.data = data;
      expQ.push_back(e);
      modelRegs[cmd[3:0]] = data;
    end
    busFrame(sel, cmd, data, 5, r);
    deselect();
    $display("txn %0d: write sel=%0d cmd=%h data=%h", txn, sel, cmd, data);
    txn++;
  endtask

  task automatic doRead(input logic [7:0] cmd);
    logic [31:0] r;
    expT e;
    e.isWrite = 1'b0;
    e.addr = cmd[3:0];
    e.data = 32'h0;
    expQ.push_back(e);
    busFrame(ADDR, cmd, 32'h0, 5, r);
    check("read_data", r, modelRegs[cmd[3:0]]);
    deselect();
    $display("txn %0d: read cmd=%h data=%h expected=%h", txn, cmd, r, modelRegs[cmd[3:0]]);
    txn++;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_miso"}, {24'd0, oBusMISO}, 32'd0);
    check({tag, "_enable"}, {31'd0, oBusMISOEnable}, 32'd0);
    check({tag, "_interrupt"}, {31'd0, oBusInterrupt}, 32'd0);
    check({tag, "_address"}, {28'd0, oLocalAddress}, 32'd0);
    check({tag, "_data"}, oLocalData, 32'd0);
    check({tag, "_write"}, {31'd0, oLocalWrite}, 32'd0);
    check({tag, "_read"}, {31'd0, oLocalRead}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  a;
    expT e;
    iReset = 1'b1;
    iBusClock = 1'b0;
    iBusSelect = 2'd0;
    iBusMOSI = 8'h00;
    iLocalData = 32'h0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      modelRegs[i] = mem[i];
    end
    #1;
    checkResetOutputs("reset");
    #40;
    iReset = 1'b0;
    #50;

    doWrite(ADDR, 8'h85, 32'h12345678);
    check("hold_address", {28'd0, oLocalAddress}, 32'h5);
    check("hold_data", oLocalData, 32'h12345678);
    doWrite(ADDR, 8'h83, 32'hDEADBEEF);
    doRead(8'h03);

    watchEnable = 1'b1;
    enHigh = 0;
    doWrite(2'd2, 8'h85, 32'hCAFEF00D);
    watchEnable = 1'b0;
    check("wrongsel_enable_cycles", enHigh, 32'd0);

    busFrame(ADDR, 8'h81, 32'hAABB0000, 3, r);
    deselect();
    $display("txn %0d: aborted write cmd=81 after two data bytes", txn);
    txn++;
    doWrite(ADDR, 8'h81, $urandom);
    doRead(8'h01);

    doWrite(ADDR, 8'h87, $urandom);
    e.isWrite = 1'b0;
    e.addr = 4'h6;
    e.data = 32'h0;
    expQ.push_back(e);
    busFrame(ADDR, 8'h06, 32'h0, 3, r);
    #13;
    iReset = 1'b1;
    #1;
    checkResetOutputs("midreset");
    #30;
    iBusSelect = 2'd0;
    #20;
    iReset = 1'b0;
    #50;
    $display("txn %0d: read cmd=06 aborted by reset after two bytes", txn);
    txn++;
    doRead(8'h07);

    for (int i = 0; i < 20; i++) begin
      a = 4'($urandom);
      if ($urandom_range(0, 1) == 1) doWrite(ADDR, {1'b1, 3'($urandom), a}, $urandom);
      else doRead({1'b0, 3'($urandom), a});
    end

    #200;
    check("queue_empty", expQ.size(), 32'd0);
    done = 1'b1;
    #20;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sysx_target.md
SYSX_TARGET -- requirements
Module: sysx_target

Interface
REQ-001 SHALL have parameter ADDRESS, default 2'd1: bus select code this target answers to; 2'd0 reserved as bus-idle, never valid.
REQ-002 SHALL have port iClock  input  1: local clock; sole clock, all state on rising edge.
REQ-003 SHALL have port iReset  input  1: asynchronous, active-high reset.
REQ-004 SHALL have port iBusClock  input  1: sysX bus clock from master, asynchronous to iClock.
REQ-005 SHALL have port iBusSelect  input  2: master device select; 0 = idle.
REQ-006 SHALL have port iBusMOSI  input  8: master-to-target byte.
REQ-007 SHALL have port oBusMISO  output  8: target-to-master byte.
REQ-008 SHALL have port oBusMISOEnable  output  1: high only while this target drives MISO (board-level tristate).
REQ-009 SHALL have port oBusInterrupt  output  1: interrupt request to master.
REQ-010 SHALL have port oLocalAddress  output  4: local register index.
REQ-011 SHALL have port oLocalData  output  32: local write data.
REQ-012 SHALL have port oLocalWrite  output  1: one-cycle write strobe.
REQ-013 SHALL have port oLocalRead  output  1: one-cycle read strobe.
REQ-014 SHALL have port iLocalData  input  32: read data, valid the cycle after oLocalRead.
REQ-015 SHALL have port iLocalInterrupt  input  1: local interrupt level.

Function
REQ-016 SHALL pass iBusClock, iBusSelect, iBusMOSI through 2-flop synchronizers; edges detected on synchronized bus clock; bus clock period SHALL be >= 8 iClock cycles (design constraint).
REQ-017 SHALL treat "selected" as synchronized iBusSelect == ADDRESS; sample iBusMOSI only on detected bus-clock rising edges while selected.
REQ-018 SHALL implement states IDLE, COMMAND, WDATA, WCOMMIT, RFETCH, RDATA, DONE.
REQ-019 IDLE -> COMMAND when selected becomes true; oBusMISOEnable SHALL assert the cycle selected is seen and deassert the cycle it drops.
REQ-020 COMMAND: first rising edge captures command byte; bit7 = 1 write, 0 read; bits[3:0] -> oLocalAddress; bits[6:4] ignored; write -> WDATA, read -> RFETCH.
REQ-021 WDATA: next four rising edges shift bytes into oLocalData, MSB byte first; after fourth -> WCOMMIT.
REQ-022 WCOMMIT: oLocalWrite high exactly one cycle, the cycle after entry; -> DONE.
REQ-023 RFETCH: oLocalRead high one cycle; next cycle latch iLocalData into 32-bit shift register; -> RDATA.
REQ-024 RDATA: on each bus-clock falling edge drive next byte on oBusMISO, MSB byte first; after fourth byte placed, -> DONE on next rising edge.
REQ-025 DONE: ignore further bus edges; oBusMISO holds last value; -> IDLE when selected drops.
REQ-026 Selected dropping in any state SHALL return to IDLE next cycle; no oLocalWrite for partial write frame; oLocalRead already issued not retracted.
REQ-027 oBusMISO SHALL be 8'h00 whenever not in RDATA/DONE.
REQ-028 oBusInterrupt SHALL equal iLocalInterrupt registered once in iClock, independent of selection.
REQ-029 oLocalWrite and oLocalRead SHALL never be high simultaneously; at most one strobe per frame.

Reset
REQ-030 iReset high SHALL immediately force state IDLE, synchronizers 0, oBusMISO 8'h00, oBusMISOEnable 0, oBusInterrupt 0, oLocalAddress 4'h0, oLocalData 32'h0, oLocalWrite 0, oLocalRead 0.
REQ-031 Reset asserted mid-frame SHALL abort frame with no strobe; after release, target waits for selected to be seen (via IDLE) before accepting a command.

Verification
REQ-032 Write: select=1, bytes 8'h85,12,34,56,78 -> single oLocalWrite pulse, oLocalAddress 4'h5, oLocalData 32'h12345678.
REQ-033 Read: select=1, byte 8'h03, iLocalData 32'hDEADBEEF -> one oLocalRead with address 4'h3; master samples DE,AD,BE,EF on rising edges 2-5.
REQ-034 Wrong select: select=2 with write frame -> no strobes, oBusMISOEnable stays 0.
REQ-035 Abort: write frame 8'h81,AA,BB then select to 0 -> no oLocalWrite, state IDLE; next full frame completes normally.
REQ-036 Reset mid-read (after second byte) -> all outputs at reset values within same cycle; subsequent read of 8'h07 returns correct data.
REQ-037 Interrupt: iLocalInterrupt toggled during idle and during transaction -> oBusInterrupt follows one cycle later, frame unaffected.
